mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 SHALL have port operand_a  input  WIDTH  rs value, taken from register-file read_data1.
REQ-007 SHALL have port operand_b  input  WIDTH  rt value, taken from register-file read_data2.
REQ-008 SHALL have port hilo_we  input  2  bit1 writes HI, bit0 writes LO (mthi/mtlo).
REQ-009 SHALL have port hilo_wdata  input  WIDTH  data for the mthi/mtlo write.
REQ-010 SHALL have port busy  output  1  high while an operation is in flight.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the result is committed.
REQ-012 SHALL have port div_by_zero  output  1  valid only while done=1.
REQ-013 SHALL have ports hi and lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-014 SHALL implement states IDLE -> RUN -> FINISH -> IDLE; busy=1 exactly in RUN and FINISH.
REQ-015 SHALL accept start only in IDLE: capture op, operand magnitudes (signed ops) and result signs, clear the 5-bit iteration counter, enter RUN; start outside IDLE is ignored.
REQ-016 SHALL process one bit per cycle in RUN (shift-add multiply or restoring divide), leaving after exactly 32 iterations.
REQ-017 SHALL, in FINISH, apply sign correction, write HI/LO, assert done for one cycle and return to IDLE.
REQ-018 SHALL meet this latency: start sampled at edge E0 -> done=1 and new HI/LO visible in the cycle after edge E33; a new start is accepted in that same cycle.
REQ-019 SHALL, for multiply, set {HI,LO} to the 64-bit product; for signed ops, negate the magnitude product when the operand signs differ.
REQ-020 SHALL, for divide, set LO=quotient and HI=remainder; signed: quotient negative iff signs differ, remainder takes the sign of operand_a.
REQ-021 SHALL, for divisor 0 (DIV or DIVU), use normal latency, set LO=all ones, HI=operand_a and div_by_zero=1 with done.
REQ-022 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give LO=0x80000000 and HI=0 with no error flag.
REQ-023 SHALL apply hilo_we writes on the next edge only in IDLE; they are ignored while busy.
REQ-024 SHALL give start priority over hilo_we when both occur in the same IDLE cycle: hilo_we is dropped.
REQ-025 SHALL leave operand_a/operand_b changes after acceptance with no effect on the result.
REQ-026 SHALL hold hi/lo stable for the whole operation until the FINISH commit.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0 and counter=0.
REQ-028 SHALL discard any in-flight operation on reset mid-operation, with no done pulse afterwards.
REQ-029 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL take the op encodings, the state enum and the WIDTH default from shared package mdu_pkg.
REQ-031 SHALL be a single module with no sub-module; one 64-bit shift register serves both multiply and divide.

Verification
REQ-032 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done in cycle 33 after start.
REQ-033 SHALL cover: MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIVU 100/7 -> LO=14, HI=2.
REQ-034 SHALL cover: DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 SHALL cover: DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234, div_by_zero=1 for one cycle.
REQ-036 SHALL cover: second start and hilo_we=11 pulsed while busy -> both ignored, first result intact.
REQ-037 SHALL cover: rst_n low 10 cycles after start -> busy=0, HI=LO=0 at once, no done; then mtlo 0x55 -> LO=0x55.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operand width,
// operation encodings, controller states and small op-decoding helpers.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } mdu_state_e;

  // Upper encoding bit selects divide, lower bit selects signed operands.
  function automatic logic op_is_div(input mdu_op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_e o);
    return o[0];
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit. Signed operations are reduced to
// magnitudes at start, one 64-bit shift register runs either a shift-add
// multiply or a restoring divide for WIDTH cycles, and signs are restored
// in the FINISH cycle when HI/LO are committed.
//
// Handshake: start is a request that is taken only in a cycle where busy is
// low (state IDLE); there is no back-pressure beyond that. Requests made
// while busy are dropped, not queued. done is a one-cycle pulse in the cycle
// after the commit edge; div_by_zero is meaningful only alongside done.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_e       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_q, op_in;
  logic [2*WIDTH-1:0] sr_q, step_val, prod_fix;
  logic [WIDTH-1:0]   b_q, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mag_a, mag_b, quot_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;
  logic [CW-1:0]      cnt_q;
  logic               neg_res_q, neg_rem_q, dbz_q;
  logic               done_q, dbz_out_q;
  logic               sign_a, sign_b;
  logic               accept, commit, last_iter;

  assign op_in  = mdu_op_e'(op);
  assign sign_a = op_is_signed(op_in) & operand_a[WIDTH-1];
  assign sign_b = op_is_signed(op_in) & operand_b[WIDTH-1];
  assign mag_a  = sign_a ? -operand_a : operand_a;
  assign mag_b  = sign_b ? -operand_b : operand_b;

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: IDLE -> RUN on start, RUN for WIDTH iterations, one FINISH cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (last_iter) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Controller outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    accept    = (state_q == ST_IDLE) && start;
    commit    = (state_q == ST_FINISH);
    last_iter = (state_q == ST_RUN) && (cnt_q == CW'(WIDTH - 1));
  end

  // One iteration of the shared shift register: shift-add multiply moves
  // right with the partial sum entering the top; restoring divide moves
  // left with quotient bits entering the bottom.
  always_comb begin
    mul_sum  = {1'b0, sr_q[2*WIDTH-1:WIDTH]} + (sr_q[0] ? {1'b0, b_q} : '0);
    div_rem  = sr_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, b_q};
    if (op_is_div(op_q)) begin
      if (div_diff[WIDTH]) step_val = {div_rem[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b0};
      else                 step_val = {div_diff[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b1};
    end else begin
      step_val = {mul_sum, sr_q[WIDTH-1:1]};
    end
  end

  // Operand capture on accept, then one iteration per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MULTU;
      sr_q      <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else if (accept) begin
      op_q      <= op_in;
      sr_q      <= {{WIDTH{1'b0}}, mag_a};
      b_q       <= mag_b;
      cnt_q     <= '0;
      neg_res_q <= sign_a ^ sign_b;
      neg_rem_q <= sign_a;
      dbz_q     <= op_is_div(op_in) && (operand_b == '0);
    end else if (state_q == ST_RUN) begin
      sr_q  <= step_val;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Sign restoration of the magnitude result.
  always_comb begin
    prod_fix = neg_res_q ? -sr_q : sr_q;
    quot_fix = neg_res_q ? -sr_q[WIDTH-1:0] : sr_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -sr_q[2*WIDTH-1:WIDTH] : sr_q[2*WIDTH-1:WIDTH];
  end

  // HI/LO next value: commit in FINISH, mthi/mtlo only in IDLE without start.
  // A zero divisor leaves the dividend magnitude in the remainder half, so
  // the sign-restored remainder is exactly operand_a.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      if (!op_is_div(op_q)) begin
        {hi_d, lo_d} = prod_fix;
      end else if (dbz_q) begin
        hi_d = rem_fix;
        lo_d = '1;
      end else begin
        hi_d = rem_fix;
        lo_d = quot_fix;
      end
    end else if ((state_q == ST_IDLE) && !start) begin
      if (hilo_we[1]) hi_d = hilo_wdata;
      if (hilo_we[0]) lo_d = hilo_wdata;
    end
  end

  // Architectural HI/LO and the registered completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= commit;
      dbz_out_q <= commit && dbz_q;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed corner cases with fixed expected values,
// plus randomized operations checked against a plain-arithmetic model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [1:0]  hilo_we = 2'b00;
  logic [31:0] hilo_wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  mdu_state_e  dbg_state;

  int n_vec = 0;
  int n_miss = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic [64:0] exp_q[$];

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {div_by_zero, HI, LO} from plain integer arithmetic.
  function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      2'b01: begin p = 64'(sa * sb); return {1'b0, p}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // driver: present a request this cycle with an explicit expectation
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [64:0] e);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    exp_q.push_back(e);
  endtask

  task automatic issue_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b, ref_model(o, a, b));
  endtask

  // Waits for done (bounded), checking busy and HI/LO hold each cycle, the
  // 34th-negedge latency and the committed result. poke_at>0 pulses a second
  // start plus hilo_we=11 at that cycle while busy.
  task automatic wait_result(input string name, input int poke_at);
    logic [64:0] e;
    bit seen;
    int lat;
    e = exp_q.pop_front();
    seen = 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        hilo_we = 2'b00;
        operand_a = $urandom;
        operand_b = $urandom;
        op = 2'($urandom_range(0, 3));
      end
      if (poke_at != 0 && k == poke_at) begin
        start = 1'b1;
        hilo_we = 2'b11;
        hilo_wdata = $urandom;
      end
      if (poke_at != 0 && k == poke_at + 1) begin
        start = 1'b0;
        hilo_we = 2'b00;
      end
      if (done) begin
        seen = 1;
        lat = k;
        break;
      end
      n_vec++;
      if (busy !== 1'b1 || hi !== model_hi || lo !== model_lo) begin
        n_miss++;
        $display("FAIL %s hold k=%0d: busy=%b hi=%h lo=%h, expected busy=1 hi=%h lo=%h",
                 name, k, busy, hi, lo, model_hi, model_lo);
      end
    end
    n_vec++;
    if (!seen || lat != 34) begin
      n_miss++;
      $display("FAIL %s latency: done seen=%0d at negedge %0d, expected negedge 34", name, seen, lat);
    end
    if (seen) begin
      n_vec++;
      if (hi !== e[63:32] || lo !== e[31:0] || div_by_zero !== e[64] || busy !== 1'b0) begin
        n_miss++;
        $display("FAIL %s result: hi=%h lo=%h dbz=%b busy=%b, expected hi=%h lo=%h dbz=%b busy=0",
                 name, hi, lo, div_by_zero, busy, e[63:32], e[31:0], e[64]);
      end
    end
    model_hi = e[63:32];
    model_lo = e[31:0];
  endtask

  task automatic idle_after(input string name);
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
      n_miss++;
      $display("FAIL %s after: done=%b dbz=%b busy=%b hi=%h lo=%h, expected 0/0/0 hi=%h lo=%h",
               name, done, div_by_zero, busy, hi, lo, model_hi, model_lo);
    end
  endtask

  task automatic mt(input logic [1:0] we, input logic [31:0] d);
    hilo_we = we;
    hilo_wdata = d;
    @(negedge clk);
    hilo_we = 2'b00;
    if (we[1]) model_hi = d;
    if (we[0]) model_lo = d;
    n_vec++;
    if (hi !== model_hi || lo !== model_lo) begin
      n_miss++;
      $display("FAIL mthi/mtlo we=%b: hi=%h lo=%h, expected hi=%h lo=%h", we, hi, lo, model_hi, model_lo);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || dbg_state !== ST_IDLE) begin
      n_miss++;
      $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h state=%0d, expected all zero/IDLE",
               busy, done, div_by_zero, hi, lo, dbg_state);
    end
    rst_n = 1'b1;
    model_hi = '0;
    model_lo = '0;
  endtask

  task automatic test_directed();
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    wait_result("multu_max", 0); idle_after("multu_max");
    issue(2'b01, 32'hFFFF_FFFD, 32'd5, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    wait_result("mult_neg3x5", 0); idle_after("mult_neg3x5");
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, {1'b0, 32'h4000_0000, 32'h0000_0000});
    wait_result("mult_minxmin", 0); idle_after("mult_minxmin");
    issue(2'b10, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
    wait_result("divu_100_7", 0); idle_after("divu_100_7");
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    wait_result("div_neg7_2", 0); idle_after("div_neg7_2");
    issue(2'b11, 32'd7, 32'hFFFF_FFFE, {1'b0, 32'd1, 32'hFFFF_FFFD});
    wait_result("div_7_neg2", 0); idle_after("div_7_neg2");
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0, 32'h8000_0000});
    wait_result("div_overflow", 0); idle_after("div_overflow");
    issue(2'b10, 32'h1234, 32'h0, {1'b1, 32'h1234, 32'hFFFF_FFFF});
    wait_result("divu_by_zero", 0); idle_after("divu_by_zero");
    issue(2'b11, 32'hFFFF_FFF9, 32'h0, {1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    wait_result("div_by_zero", 0); idle_after("div_by_zero");
  endtask

  task automatic test_hilo_write();
    mt(2'b01, 32'h0000_0055);
    mt(2'b10, 32'hA5A5_0001);
    mt(2'b11, 32'h1357_9BDF);
    mt(2'b00, 32'hFFFF_0000);
  endtask

  task automatic test_start_priority();
    mt(2'b11, 32'h0BAD_F00D);
    issue(2'b00, 32'd3, 32'd4, {1'b0, 32'h0, 32'd12});
    hilo_we = 2'b11;
    hilo_wdata = 32'hDEAD_BEEF;
    wait_result("start_vs_hilo_we", 0);
    idle_after("start_vs_hilo_we");
  endtask

  task automatic test_busy_ignore();
    bit extra;
    mt(2'b11, 32'h7777_7777);
    issue(2'b10, 32'd1000, 32'd3, {1'b0, 32'd1, 32'd333});
    wait_result("busy_ignore", 5);
    idle_after("busy_ignore");
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) extra = 1;
    end
    n_vec++;
    if (extra) begin
      n_miss++;
      $display("FAIL busy_ignore late: done or busy rose after completion, expected idle");
    end
  endtask

  task automatic test_back_to_back();
    issue_model(2'b01, pick(), pick());
    wait_result("b2b_0", 0);
    issue_model(2'b11, 32'($urandom), 32'($urandom_range(1, 1000)));
    wait_result("b2b_1", 0);
    issue_model(2'b00, 32'($urandom), 32'($urandom));
    wait_result("b2b_2", 0);
    idle_after("b2b_2");
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    mt(2'b11, 32'hCAFE_0001);
    issue_model(2'b01, 32'($urandom), 32'($urandom));
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    model_hi = '0;
    model_lo = '0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || dbg_state !== ST_IDLE) begin
      n_miss++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h state=%0d, expected 0/0/0/0/IDLE",
               busy, done, hi, lo, dbg_state);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1;
    end
    n_vec++;
    if (saw_done) begin
      n_miss++;
      $display("FAIL reset_mid discard: done/busy seen after reset, expected none");
    end
    mt(2'b01, 32'h0000_0055);
  endtask

  task automatic test_first_edge();
    @(negedge clk);
    rst_n = 1'b0;
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b10, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
    wait_result("first_edge", 0);
    idle_after("first_edge");
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) mt(2'($urandom_range(1, 3)), 32'($urandom));
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
      issue_model(o, a, b);
      wait_result("random", 0);
      if ($urandom_range(0, 1) == 0) idle_after("random");
    end
    idle_after("random_end");
  endtask

  // sequence + report
  initial begin
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_directed();
    test_hilo_write();
    test_start_priority();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_first_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
